// File: rtl/router_pkg.sv
// Shared types and helpers for the scratchpad routers: precision modes,
// output-router FSM states, and the lanes-per-word calculation.
package router_pkg;

    typedef enum logic [1:0] {
        P_8B = 2'b00,
        P_4B = 2'b01,
        P_2B = 2'b10
    } p_mode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_DONE    = 2'b10
    } out_state_t;

    // Mode 11 has no meaning of its own and runs as full precision.
    function automatic p_mode_t decode_mode(input logic [1:0] raw);
        return (raw == 2'b11) ? P_8B : p_mode_t'(raw);
    endfunction

    // Halving the lane width doubles the number of lanes in a word.
    function automatic int unsigned lanes_per_word(input p_mode_t mode,
                                                   input int unsigned data_length);
        return data_length << mode;
    endfunction

endpackage

// File: rtl/spad.sv
// Output scratchpad: one write port, one registered read port.
// A read and a write to the same address on the same edge return old data.
module spad #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage array, no reset so contents survive clears.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; valid is a one-cycle pulse per request.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/word_packer.sv
// Packs incoming elements into SPAD words, lane 0 at the LSBs.
// Emits a word when the last lane fills or on a flush with pending lanes.
// Optional macro OUTPUT_ROUTER_RELU_EN: negative elements (signed at the
// current lane width) are packed as zero.
module word_packer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 8,
    parameter int SPAD_DATA_WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       clear,
    input  logic                       start,
    input  p_mode_t                    mode,
    input  logic                       accept,
    input  logic [DATA_WIDTH-1:0]      data,
    input  logic                       flush,
    output logic                       fire,
    output logic [SPAD_DATA_WIDTH-1:0] word
);

    localparam int LCW = $clog2(DATA_LENGTH * 4) + 1;
    localparam int LWW = $clog2(DATA_WIDTH) + 1;
    localparam int SHW = $clog2(SPAD_DATA_WIDTH);

    logic [SPAD_DATA_WIDTH-1:0] buffer, merged, elem;
    logic [LCW-1:0]             lane_cnt, lanes;
    logic [LWW-1:0]             lane_w;
    logic [SHW-1:0]             shamt;
    logic                       full;
`ifdef OUTPUT_ROUTER_RELU_EN
    logic                       sign;
`endif

    // Merge the incoming element into the buffer and decide whether a word leaves.
    always_comb begin
        lane_w = LWW'(DATA_WIDTH >> mode);
        lanes  = LCW'(lanes_per_word(mode, DATA_LENGTH));
        elem   = '0;
`ifdef OUTPUT_ROUTER_RELU_EN
        sign   = 1'b0;
`endif
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (b < int'(lane_w)) elem[b] = data[b];
`ifdef OUTPUT_ROUTER_RELU_EN
            if (b == int'(lane_w) - 1) sign = data[b];
`endif
        end
`ifdef OUTPUT_ROUTER_RELU_EN
        if (sign) elem = '0;
`endif
        shamt  = SHW'(int'(lane_cnt) * int'(lane_w));
        merged = buffer;
        if (accept) merged = buffer | (elem << shamt);
        full = accept && (lane_cnt == lanes - LCW'(1));
        // A flush still writes when the element accepted with it is the first lane.
        fire = full || (flush && ((lane_cnt != '0) || accept));
        word = merged;
    end

    // Lane counter and buffer; both restart after every emitted word.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            buffer   <= '0;
            lane_cnt <= '0;
        end else if (clear || start || fire) begin
            buffer   <= '0;
            lane_cnt <= '0;
        end else if (accept) begin
            buffer   <= merged;
            lane_cnt <= lane_cnt + LCW'(1);
        end
    end

endmodule

// File: rtl/output_router.sv
// Output router: collects PE results, packs them by precision mode into
// SPAD words written to consecutive (wrapping) addresses, and exposes a
// host read port. Optional macro OUTPUT_ROUTER_RELU_EN enables ReLU
// clamping inside the packer.
module output_router
    import router_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_en,
    input  logic [1:0]                 i_p_mode,
    input  logic [ADDR_WIDTH-1:0]      i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_word_count,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_data_valid,
    input  logic                       i_flush,
    output logic                       o_ready,
    output logic                       o_done,
    input  logic                       i_read_en,
    input  logic [ADDR_WIDTH-1:0]      i_read_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_data,
    output logic                       o_data_valid
);

    out_state_t                 state, state_nx;
    p_mode_t                    mode;
    logic [ADDR_WIDTH-1:0]      start_addr, word_count, word_cnt;
    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [SPAD_DATA_WIDTH-1:0] wr_data, word;
    logic                       collect, accept, flush_c, fire, last_word, start;

    assign collect   = (state == S_COLLECT);
    assign accept    = i_data_valid && collect;
    assign flush_c   = i_flush && collect;
    assign start     = i_en && !i_reg_clear && (state == S_IDLE || state == S_DONE);
    assign last_word = fire && (word_cnt + ADDR_WIDTH'(1) == word_count);

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (i_en) state_nx = (i_word_count == '0) ? S_DONE : S_COLLECT;
            S_COLLECT:      if (i_flush || last_word) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
        if (i_reg_clear) state_nx = S_IDLE;
    end

    // Outputs; done waits until the final registered write has landed.
    always_comb begin
        o_ready = collect;
        o_done  = (state == S_DONE) && !wr_en;
    end

    // Transfer parameters, word counter and the one-deep write register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            mode       <= P_8B;
            start_addr <= '0;
            word_count <= '0;
            word_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else if (i_reg_clear) begin
            word_cnt <= '0;
            wr_en    <= 1'b0;
        end else begin
            wr_en <= fire;
            if (fire) begin
                wr_addr  <= start_addr + word_cnt;
                wr_data  <= word;
                word_cnt <= word_cnt + ADDR_WIDTH'(1);
            end
            if (start) begin
                mode       <= decode_mode(i_p_mode);
                start_addr <= i_start_addr;
                word_count <= i_word_count;
                word_cnt   <= '0;
            end
        end
    end

    word_packer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_LENGTH     (DATA_LENGTH),
        .SPAD_DATA_WIDTH (SPAD_DATA_WIDTH)
    ) u_packer (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .clear  (i_reg_clear),
        .start  (start),
        .mode   (mode),
        .accept (accept),
        .data   (i_data),
        .flush  (flush_c),
        .fire   (fire),
        .word   (word)
    );

    spad #(
        .DATA_WIDTH (SPAD_DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_spad (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (i_read_en),
        .rd_addr  (i_read_addr),
        .rd_data  (o_data),
        .rd_valid (o_data_valid)
    );

endmodule

// File: doc/output_router.md
# output_router

Write-side counterpart of the weight router. It sits between the PE array outputs and an output scratchpad. It accepts a stream of result elements, packs them into `SPAD_DATA_WIDTH`-bit words according to precision mode, and writes the words to consecutive SPAD addresses. The host reads the finished words back through a registered read port.

## Interface
- `SPAD_DATA_WIDTH`, 64: SPAD word width; must equal `DATA_WIDTH*DATA_LENGTH`.
- `ADDR_WIDTH`, 8: SPAD address width.
- `DATA_WIDTH`, 8: element width at full precision.
- `DATA_LENGTH`, 8: full-precision lanes per word.

- `i_clk` in 1: clock.
- `i_nrst` in 1: reset, asynchronous, active-low.
- `i_reg_clear` in 1: synchronous abort/clear, highest priority after reset.
- `i_en` in 1: start pulse, sampled in IDLE.
- `i_p_mode` in 2: precision mode, latched at start. 00 = DATA_WIDTH, 01 = DATA_WIDTH/2, 10 = DATA_WIDTH/4, 11 = treated as 00.
- `i_start_addr` in ADDR_WIDTH: first write address, latched at start.
- `i_word_count` in ADDR_WIDTH: words to write, latched at start.
- `i_data` in DATA_WIDTH: element; reduced modes use the low bits.
- `i_data_valid` in 1: element present.
- `i_flush` in 1: end transfer early.
- `o_ready` in/out: out 1; element accepted at an edge where `i_data_valid & o_ready`.
- `o_done` out 1: transfer complete; held until `i_reg_clear` or `i_en`.
- `i_read_en` in 1: host SPAD read.
- `i_read_addr` in ADDR_WIDTH: host read address.
- `o_data` out SPAD_DATA_WIDTH: read data.
- `o_data_valid` out 1: `o_data` valid.

## Operation
- FSM states are IDLE, COLLECT, DONE. Reset state is IDLE.
- IDLE → COLLECT on `i_en`.
  - Latch mode, start address and count.
  - Clear the lane counter and the word counter.
  - If `i_word_count`=0, go IDLE → DONE directly and perform no writes.
- COLLECT:
  - `o_ready`=1.
  - Each accepted element goes into the lane at index `lane_cnt`. Lane 0 is at the LSBs.
  - Lane width is DATA_WIDTH>>mode.
  - Lanes per word are DATA_LENGTH<<mode.
- Word full:
  - Register the packed word and the address `start+word_cnt`, computed mod 2^ADDR_WIDTH so it wraps.
  - Increment `word_cnt` and reset `lane_cnt`.
  - The packing buffer is cleared to zero after every write.
- When the final word is written (`word_cnt` reaches count), go COLLECT → DONE.
- `i_flush` in COLLECT:
  - If `lane_cnt`>0, the partial word is written zero-padded.
  - The FSM then goes to DONE.
  - If `lane_cnt`=0, there is no write; go to DONE.
- Flush together with a valid element: the element is accepted first.
  - If the element completes the word, exactly one write occurs.
- DONE: `o_done`=1 and `o_ready`=0. `i_en` starts a new transfer.
- Elements presented while `o_ready`=0 are ignored.
- `i_reg_clear`:
  - Returns the FSM to IDLE and clears counters, buffer and `o_done`.
  - Cancels any registered but unperformed write.
  - SPAD contents are kept.
- The host read port is usable in any state.

## Timing
- Reset values: `o_ready`=0, `o_done`=0, `o_data`=0, `o_data_valid`=0.
- `o_ready` rises the cycle after the `i_en` edge.
- Write latency: the last element of a word is accepted at edge N. The SPAD write enable is high during cycle N+1, and the write occurs at edge N+1.
- `o_done` timing:
  - Final write: `o_done` rises at edge N+1.
  - Empty flush (no write): `o_done` rises at the flush edge.
- Read: `i_read_en` at edge R gives `o_data`/`o_data_valid` at R+1. `o_data_valid` is a single-cycle pulse per read.
- A read and a write to the same address at the same edge return the old contents.
- Full throughput: one element per cycle with no bubbles at word boundaries.

## Configuration
- Macro: `OUTPUT_ROUTER_RELU_EN`.
- Defined: each element is treated as signed at its lane width. Negative values are packed as 0.
- Undefined: elements are packed unmodified.

## Structure
- `router_pkg` holds:
  - the `p_mode_t` enum (P_8B, P_4B, P_2B);
  - the `out_state_t` enum;
  - the function computing lanes-per-word from mode.
- Sub-module `word_packer`: lane counter, shift-in buffer, full/flush word output, and the optional ReLU.
- The existing `spad` is instantiated for storage.

## Test plan
All scenarios use DATA_WIDTH=8 and DATA_LENGTH=8.
- **Mode 00:** start 0x10, count 2, elements 0x01..0x10 back-to-back. Expected SPAD[0x10]=0x0807060504030201 and SPAD[0x11]=0x100F0E0D0C0B0A09. `o_done` rises one cycle after the 16th accept.
- **Mode 01:** count 1, 16 elements with low nibbles 1..F,0. Expected SPAD[start]=0x0FEDCBA987654321.
- **Flush:** count 4, elements 0xAA,0xBB,0xCC, then `i_flush`. Expected SPAD[start]=0x0000000000CCBBAA, exactly one write, DONE.
- **Clear mid-word:** `i_reg_clear` after 5 elements. Expect no write, IDLE, `o_ready`=0, `o_done`=0; prior SPAD data unchanged.
- **Address wrap:** start 0xFF, count 2. Expect writes to 0xFF then 0x00.
- **ReLU macro:** in mode 00, element 0x80. Stored as 0x00 with `OUTPUT_ROUTER_RELU_EN` defined, 0x80 without it. Read back via `i_read_en` shows `o_data_valid` one cycle later.
